// File: rtl/incdev_pkg.sv
// incdev_pkg: shared state encoding, widths and queue entry type for the execute queue
package incdev_pkg;
  localparam int INST_W = 32;
  localparam int PC_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_e;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;
endpackage

// File: rtl/incdev_sync_fifo.sv
// incdev_sync_fifo: circular FIFO with separate occupancy count; push while full succeeds only alongside a pop
module incdev_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_wr, w_rd;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk)
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_wr);
      r_rd  <= r_rd + AW'(w_rd);
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
    end
  // storage needs no reset; occupancy alone defines validity
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/incdev_ex_queue.sv
// incdev_ex_queue: buffers execute requests and issues them one at a time with a watchdog; INCDEV_EXQ_BYPASS_EN adds an empty-queue bypass
module incdev_ex_queue
  import incdev_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [INST_W-1:0]      in_inst,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   full,
  output logic                   usr_ex_flag,
  output logic [INST_W-1:0]      usr_ex_inst,
  output logic [PC_W-1:0]        usr_ex_pc,
  input  logic                   usr_ex_finish,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf_err,
  output logic                   timeout_err,
  output logic [PC_W-1:0]        err_pc
);
  localparam int WW = $clog2(TIMEOUT);
  state_e        r_state, w_next;
  entry_t        r_cur, w_head, w_in;
  logic [WW-1:0] r_wd;
  logic          r_ovf, r_to;
  logic [PC_W-1:0] r_err_pc;
  logic          w_empty, w_pop, w_byp, w_push, w_ovf, w_exp;
  assign w_in = '{pc: in_pc, inst: in_inst};
  assign w_pop = r_state == IDLE && !w_empty;
`ifdef INCDEV_EXQ_BYPASS_EN
  assign w_byp = r_state == IDLE && w_empty && in_valid;
`else
  assign w_byp = 1'b0;
`endif
  assign w_push = in_valid && !w_byp;
  assign w_ovf  = w_push && full && !w_pop;
  assign w_exp  = r_state == WAIT && !usr_ex_finish && r_wd == WW'(TIMEOUT - 1);
  assign usr_ex_flag = r_state == ISSUE;
  assign busy        = r_state == ISSUE || r_state == WAIT;
  assign usr_ex_inst = r_cur.inst;
  assign usr_ex_pc   = r_cur.pc;
  assign ovf_err     = r_ovf;
  assign timeout_err = r_to;
  assign err_pc      = r_err_pc;
  incdev_sync_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_data(w_in),
    .o_data(w_head), .o_full(full), .o_empty(w_empty), .o_count(count)
  );
  // next state: finish beats a simultaneous watchdog expiry
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_pop || w_byp) ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = usr_ex_finish ? IDLE : w_exp ? ERR : WAIT;
      default: w_next = ERR;
    endcase
  end
  // state, issued entry, watchdog and sticky error capture
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= IDLE;
      r_cur    <= '0;
      r_wd     <= '0;
      r_ovf    <= 1'b0;
      r_to     <= 1'b0;
      r_err_pc <= '0;
    end else begin
      r_state <= w_next;
      r_cur   <= w_pop ? w_head : w_byp ? w_in : r_cur;
      r_wd    <= r_state == ISSUE ? '0 : r_state == WAIT ? r_wd + WW'(1) : r_wd;
      if (w_ovf) r_ovf <= 1'b1;
      if (w_exp) begin
        r_to     <= 1'b1;
        r_err_pc <= r_cur.pc;
      end
    end
endmodule

// File: tb/tb_incdev_ex_queue.sv
// tb_incdev_ex_queue: randomized scoreboard bench against a queue-level reference model
module tb_incdev_ex_queue;
  localparam int D = 8;
  localparam int T = 16;
  typedef struct packed {logic [31:0] inst; logic [31:0] pc;} ent_t;
  logic clk = 0;
  logic rst, in_valid, usr_ex_finish;
  logic [31:0] in_inst, in_pc;
  logic full, usr_ex_flag, busy, ovf_err, timeout_err;
  logic [31:0] usr_ex_inst, usr_ex_pc, err_pc;
  logic [$clog2(D):0] count;
  // model: phase 0 idle, 1 issue pulse, 2 running, 3 dead after timeout
  ent_t m_q[$];
  ent_t exp_q[$];
  ent_t m_cur;
  int m_ph, m_age;
  bit m_ovf, m_to;
  logic [31:0] m_epc;
  int tests = 0, fails = 0;
  logic [31:0] pcn = 32'h1C00_1000;

  incdev_ex_queue #(.DEPTH(D), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .full(full), .usr_ex_flag(usr_ex_flag), .usr_ex_inst(usr_ex_inst), .usr_ex_pc(usr_ex_pc),
    .usr_ex_finish(usr_ex_finish), .busy(busy), .count(count), .ovf_err(ovf_err),
    .timeout_err(timeout_err), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    exp_q.delete();
    m_cur = '0;
    m_ph = 0;
    m_age = 0;
    m_ovf = 0;
    m_to = 0;
    m_epc = '0;
  endtask

  task automatic m_step(bit v, ent_t e, bit f);
    bit pop, byp, acc;
    pop = m_ph == 0 && m_q.size() > 0;
    byp = 0;
`ifdef INCDEV_EXQ_BYPASS_EN
    byp = m_ph == 0 && m_q.size() == 0 && v;
`endif
    acc = v && !byp && (m_q.size() < D || pop);
    if (v && !byp && !acc) m_ovf = 1;
    case (m_ph)
      0: if (pop) begin m_cur = m_q.pop_front(); m_ph = 1; end
         else if (byp) begin m_cur = e; m_ph = 1; end
      1: begin m_ph = 2; m_age = 0; end
      2: if (f) m_ph = 0;
         else if (m_age == T - 1) begin m_to = 1; m_epc = m_cur.pc; m_ph = 3; end
         else m_age++;
      default: ;
    endcase
    if (acc) m_q.push_back(e);
    if (acc || byp) exp_q.push_back(e);
  endtask

  task automatic cyc(bit r, bit v, logic [31:0] i, logic [31:0] p, bit f);
    @(negedge clk);
    rst = r; in_valid = v; in_inst = i; in_pc = p; usr_ex_finish = f;
    if (r) m_reset();
    else m_step(v, '{inst: i, pc: p}, f);
  endtask

  task automatic push(logic [31:0] p, bit f);
    cyc(0, 1, $urandom, p, f);
  endtask

  task automatic idle(int n, int d);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, m_ph == 2 && m_age >= d);
  endtask

  // monitor: compares every cycle and pops the scoreboard on each issue pulse
  always @(posedge clk) begin
    ent_t e;
    #1;
    chk("usr_ex_flag", usr_ex_flag, 32'(m_ph == 1));
    chk("busy", busy, 32'(m_ph == 1 || m_ph == 2));
    chk("count", 32'(count), m_q.size());
    chk("full", full, 32'(m_q.size() == D));
    chk("ovf_err", ovf_err, m_ovf);
    chk("timeout_err", timeout_err, m_to);
    chk("err_pc", err_pc, m_epc);
    chk("usr_ex_pc", usr_ex_pc, m_cur.pc);
    chk("usr_ex_inst", usr_ex_inst, m_cur.inst);
    if (usr_ex_flag === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_order: issued pc %h, want no issue", usr_ex_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_inst", usr_ex_inst, e.inst);
        chk("sb_pc", usr_ex_pc, e.pc);
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; in_inst = 0; in_pc = 0; usr_ex_finish = 0;
    m_reset();
    cyc(1, 0, 0, 0, 0);
    // single instruction into an empty queue
    cyc(0, 1, 32'h0280_0421, 32'h1C00_0000, 0);
    idle(10, 2);
    // burst of ten back-to-back pushes with no finish, then drain
    for (int i = 0; i < 10; i++) push(32'h1C00_0100 + 32'(4 * i), 0);
    idle(80, $urandom_range(0, 3));
    cyc(1, 0, 0, 0, 0);
    // fill while running, then push on the idle pop cycle while full
    for (int i = 0; i < 9; i++) push(32'h1C00_0200 + 32'(4 * i), 0);
    cyc(0, 0, 0, 0, m_ph == 2);
    push(32'h1C00_02F0, 0);
    idle(80, 1);
    cyc(1, 0, 0, 0, 0);
    // random traffic with wrap-around and spurious finishes
    for (int i = 0; i < 400; i++) begin
      bit v = $urandom_range(0, 3) == 0;
      bit f = m_ph == 2 ? (m_age >= 10 || $urandom_range(0, 2) == 0) : $urandom_range(0, 7) == 0;
      cyc(0, v, $urandom, pcn, f);
      if (v) pcn += 4;
    end
    // finish coinciding with watchdog expiry wins
    push(32'h1C00_0300, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, m_ph == 2 && m_age == T - 1);
    idle(80, 1);
    chk("sb_drained", exp_q.size(), 0);
    // timeout with pushes continuing into ERR until overflow
    cyc(1, 0, 0, 0, 0);
    push(32'h1C00_0040, 0);
    for (int i = 0; i < 12; i++) push(32'h1C00_0400 + 32'(4 * i), 0);
    idle(15, 99);
    cyc(1, 0, 0, 0, 0);
    // reset mid-wait abandons the instruction; a later finish is ignored
    push(32'h1C00_0500, 0);
    idle(4, 99);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    idle(3, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
